// File: rtl/bitwise_logic_pipe_if.sv
// rtl/bitwise_logic_pipe_if.sv - operand/result handshake bundle for bitwise_logic_pipe
// Purpose: groups the request side (in_valid/in_ready/op/A/B), the response side
//   (out_valid/out_ready/Out) and the busy status of the bitwise logic unit.
// Signals: in_valid, op[2:0], A, B, out_ready driven by the master;
//   in_ready, out_valid, Out, busy (plus out_zero/out_parity when BLU_FLAGS_EN)
//   driven by the slave.
// Config macro: BLU_FLAGS_EN adds the out_zero/out_parity result flags.
interface bitwise_logic_pipe_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Out;
  logic             busy;
`ifdef BLU_FLAGS_EN
  logic             out_zero;
  logic             out_parity;
`endif

  modport master (
    output in_valid, op, A, B, out_ready,
`ifdef BLU_FLAGS_EN
    input  out_zero, out_parity,
`endif
    input  in_ready, out_valid, Out, busy
  );

  modport slave (
    input  in_valid, op, A, B, out_ready,
`ifdef BLU_FLAGS_EN
    output out_zero, out_parity,
`endif
    output in_ready, out_valid, Out, busy
  );
endinterface

// File: rtl/bitwise_logic_pipe.sv
// rtl/bitwise_logic_pipe.sv - pipelined 8-op bitwise logic unit with valid/ready flow control
// Purpose: computes one of AND/OR/XOR/XNOR/NAND/NOR/NOT A/pass A on A,B, captures the
//   result into stage 0 on an input transfer and carries it through STAGES register
//   stages; bubbles collapse so a stalled output lets upstream stages fill.
// Ports: clk, rst_n (asynchronous, active-low);
//   bus (bitwise_logic_pipe_if.slave): in_valid/op/A/B/out_ready in,
//   in_ready/out_valid/Out/busy out.
// Parameters: WIDTH operand width, STAGES pipeline depth (1..4) = latency in cycles.
// Config macro: BLU_FLAGS_EN adds out_zero (Out==0) and out_parity (^Out), computed at
//   capture and carried alongside the data.
module bitwise_logic_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  bitwise_logic_pipe_if.slave bus
);
`ifdef BLU_FLAGS_EN
  localparam int DW = WIDTH + 2;  // {parity, zero, result}
`else
  localparam int DW = WIDTH;
`endif
  localparam int LAST = STAGES - 1;

  logic [WIDTH-1:0]  res;
  logic [DW-1:0]     cap;
  logic              in_ready;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic [DW-1:0]     data_q [STAGES];
  logic [DW-1:0]     data_d [STAGES];

  always_comb begin
    res = bus.A;
    case (bus.op)
      3'b000: res = bus.A & bus.B;
      3'b001: res = bus.A | bus.B;
      3'b010: res = bus.A ^ bus.B;
      3'b011: res = ~(bus.A ^ bus.B);
      3'b100: res = ~(bus.A & bus.B);
      3'b101: res = ~(bus.A | bus.B);
      3'b110: res = ~bus.A;
      3'b111: res = bus.A;
    endcase
  end

`ifdef BLU_FLAGS_EN
  assign cap = {^res, ~|res, res};
`else
  assign cap = res;
`endif

  // A stage advances when it holds data and its downstream can take it; the
  // chain is resolved from the output back, so out_ready reaches in_ready
  // combinationally and a full pipe still streams at one result per cycle.
  always_comb begin
    adv       = '0;
    adv[LAST] = v_q[LAST] & bus.out_ready;
    for (int i = LAST - 1; i >= 0; i--) begin
      adv[i] = v_q[i] & (~v_q[i+1] | adv[i+1]);
    end
    in_ready = ~v_q[0] | adv[0];
    load     = '0;
    load[0]  = bus.in_valid & in_ready;
    for (int i = 1; i < STAGES; i++) begin
      load[i] = adv[i-1];
    end
    v_d = (v_q & ~adv) | load;
    for (int i = 0; i < STAGES; i++) begin
      data_d[i] = data_q[i];
    end
    if (load[0]) data_d[0] = cap;
    for (int i = 1; i < STAGES; i++) begin
      if (load[i]) data_d[i] = data_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = v_q[LAST];
  assign bus.Out       = data_q[LAST][WIDTH-1:0];
  assign bus.busy      = |v_q;
`ifdef BLU_FLAGS_EN
  assign bus.out_zero   = data_q[LAST][WIDTH];
  assign bus.out_parity = data_q[LAST][WIDTH+1];
`endif
endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// tb/tb_bitwise_logic_pipe.sv - self-checking bench for bitwise_logic_pipe
module tb_bitwise_logic_pipe;
  parameter int STAGES = 2;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bitwise_logic_pipe_if #(.WIDTH(W)) bus ();

  bitwise_logic_pipe #(.WIDTH(W), .STAGES(STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_in     = 0;
  int n_out    = 0;
  logic [W-1:0] sb_q [$];
  logic [W-1:0] obs_q [$];
  int           obs_cyc [$];
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_out;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a ^ b);
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return ~a;
      default: return a;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: handshake inputs are stable from negedge to the next posedge,
  // so a transfer seen here is the one the coming edge performs.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (prev_stall) begin
        check_eq("hold_valid", W'(bus.out_valid), 1);
        check_eq("hold_data", bus.Out, prev_out);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = bus.Out;
      if (bus.in_valid && bus.in_ready) begin
        sb_q.push_back(ref_op(bus.op, bus.A, bus.B));
        n_in++;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        obs_q.push_back(bus.Out);
        obs_cyc.push_back(cyc);
        check_eq("sb_pending", W'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) check_eq("sb_data", bus.Out, sb_q.pop_front());
`ifdef BLU_FLAGS_EN
        check_eq("flag_zero", W'(bus.out_zero), W'(bus.Out == '0));
        check_eq("flag_parity", W'(bus.out_parity), W'(^bus.Out));
`endif
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      output int waits);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.A = a;
    bus.B = b;
    waits = 0;
    @(negedge clk);
    while (!bus.in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    check_eq("send_accept", W'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.out_ready = 1'b1;
    while ((sb_q.size() != 0 || bus.busy) && n < 100) begin
      tick();
      n++;
    end
    check_eq("drain_idle", W'(bus.busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, wsum, lat, base;
    logic [W-1:0] held;
    logic [W-1:0] exp4 [$];
    logic [W-1:0] t3 [8];
    logic [2:0] op;
    logic [W-1:0] a, b;

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.A = '0;
    bus.B = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_out_valid", W'(bus.out_valid), 0);
    check_eq("rst_out", bus.Out, 0);
    check_eq("rst_busy", W'(bus.busy), 0);
    check_eq("rst_in_ready", W'(bus.in_ready), 1);
    tick();

    // Test 1: single XNOR, latency
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.op = 3'b011;
    bus.A = 64'hAAAA_BBBB_CCCC_DDDD;
    bus.B = 64'h1111_2222_3333_4444;
    lat = 0;
    do begin
      tick();
      bus.in_valid = 1'b0;
      lat++;
    end while (!bus.out_valid && lat < 20);
    check_eq("t1_latency", W'(lat), W'(STAGES));
    check_eq("t1_out", bus.Out, 64'h4444_6666_0000_6666);
    drain();

    // Test 2: back-to-back XNOR
    obs_q.delete();
    obs_cyc.delete();
    send(3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, w);
    wsum = w;
    send(3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1111_1111_1111_1111, w);
    wsum += w;
    drain();
    check_eq("t2_waits", W'(wsum), 0);
    check_eq("t2_count", W'(obs_q.size()), 2);
    if (obs_q.size() == 2) begin
      check_eq("t2_r0", obs_q[0], 64'h1);
      check_eq("t2_r1", obs_q[1], 64'h1111_1111_1111_1111);
      check_eq("t2_b2b", W'(obs_cyc[1] - obs_cyc[0]), 1);
    end

    // Test 3: all eight ops streamed
    t3 = '{64'hF000_F000_F000_F000, 64'hFFF0_FFF0_FFF0_FFF0, 64'h0FF0_0FF0_0FF0_0FF0,
           64'hF00F_F00F_F00F_F00F, 64'h0FFF_0FFF_0FFF_0FFF, 64'h000F_000F_000F_000F,
           64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0};
    obs_q.delete();
    obs_cyc.delete();
    wsum = 0;
    for (int k = 0; k < 8; k++) begin
      send(3'(k), 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, w);
      wsum += w;
    end
    drain();
    check_eq("t3_waits", W'(wsum), 0);
    check_eq("t3_count", W'(obs_q.size()), 8);
    if (obs_q.size() == 8) begin
      for (int k = 0; k < 8; k++) check_eq($sformatf("t3_op%0d", k), obs_q[k], t3[k]);
      check_eq("t3_span", W'(obs_cyc[7] - obs_cyc[0]), 7);
    end

    // Test 4: stall fills exactly STAGES entries
    tick();
    obs_q.delete();
    exp4.delete();
    bus.out_ready = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      op = 3'($urandom);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      exp4.push_back(ref_op(op, a, b));
      send(op, a, b, w);
      check_eq("t4_accept", W'(w), 0);
    end
    op = 3'($urandom);
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    exp4.push_back(ref_op(op, a, b));
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.A = a;
    bus.B = b;
    @(negedge clk);
    check_eq("t4_full_rdy", W'(bus.in_ready), 0);
    check_eq("t4_ovalid", W'(bus.out_valid), 1);
    check_eq("t4_head", bus.Out, exp4[0]);
    held = bus.Out;
    repeat (3) begin
      @(negedge clk);
      check_eq("t4_hold", bus.Out, held);
      check_eq("t4_rdy_low", W'(bus.in_ready), 0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq("t4_rdy_pass", W'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    drain();
    check_eq("t4_count", W'(obs_q.size()), W'(STAGES + 1));
    if (obs_q.size() == STAGES + 1)
      for (int k = 0; k <= STAGES; k++) check_eq($sformatf("t4_r%0d", k), obs_q[k], exp4[k]);

    // Test 5: asynchronous reset mid-operation
    bus.out_ready = 1'b0;
    for (int k = 0; k < STAGES; k++) send(3'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, w);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_ovalid", W'(bus.out_valid), 0);
    check_eq("t5_busy", W'(bus.busy), 0);
    check_eq("t5_out", bus.Out, 0);
    sb_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    obs_q.delete();
    bus.out_ready = 1'b1;
    repeat (5) tick();
    check_eq("t5_no_stale", W'(obs_q.size()), 0);
    check_eq("t5_in_ready", W'(bus.in_ready), 1);

    // Test 6: XOR to zero (flags when enabled)
    obs_q.delete();
    send(3'b010, 64'hDEAD_BEEF_DEAD_BEEF, 64'hDEAD_BEEF_DEAD_BEEF, w);
    drain();
    check_eq("t6_count", W'(obs_q.size()), 1);
    if (obs_q.size() == 1) check_eq("t6_zero", obs_q[0], 0);

    // Random traffic with random backpressure
    base = n_out - n_in;
    for (int c = 0; c < 400; c++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.op = 3'($urandom);
      bus.A = {$urandom, $urandom};
      bus.B = {$urandom, $urandom};
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.in_valid = 1'b0;
    drain();
    check_eq("rnd_flushed", W'(sb_q.size()), 0);
    check_eq("rnd_balance", W'(n_out - n_in), W'(base));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
